// File: rtl/speed_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// speed_ctrl_fsm
// Control unit for the vehicle speed/barrier datapath. It synchronizes the
// road and exit sensors and steps the datapath through its init, count, cal
// and barrier phases by driving single-cycle strobes. It also decides whether
// to admit a vehicle and flags overspeed.
//
// Parameters:
//   WIDTH_SPEED  width of the speed quotient
//   SPEED_LIMIT  speed values strictly above this set overspeed
//   MAX_VEH      num_veh value at which the lot is full
//   TIMEOUT_CYC  cycle budget for the COUNT and WAIT_DIV phases
//   OPEN_CYC     number of cycles the barrier enable is held
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   sen1, sen2, exit_sen  asynchronous sensor levels (only rising edges act)
//   done                  divider result valid
//   num_veh               current vehicle count from the datapath
//   speed                 divider quotient
//   init, count, cal      datapath phase strobes (registered)
//   up, down              vehicle counter increment / decrement (registered)
//   en, dis               barrier enable window / barrier disable pulse
//   overspeed             last measured vehicle exceeded SPEED_LIMIT
//   busy                  FSM not in IDLE, delayed by one cycle
// ---------------------------------------------------------------------------
module speed_ctrl_fsm #(
   parameter int unsigned WIDTH_SPEED = 14,
   parameter int unsigned SPEED_LIMIT = 60,
   parameter int unsigned MAX_VEH     = 3,
   parameter int unsigned TIMEOUT_CYC = 50000000,
   parameter int unsigned OPEN_CYC    = 250000000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sen1,
   input  logic                   sen2,
   input  logic                   exit_sen,
   input  logic                   done,
   input  logic [1:0]             num_veh,
   input  logic [WIDTH_SPEED-1:0] speed,
   output logic                   init,
   output logic                   count,
   output logic                   cal,
   output logic                   up,
   output logic                   down,
   output logic                   en,
   output logic                   dis,
   output logic                   overspeed,
   output logic                   busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
   localparam int unsigned OPN_W = $clog2(OPEN_CYC + 1);

   localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [OPN_W-1:0]       OPEN_LAST = OPN_W'(OPEN_CYC - 1);
   localparam logic [WIDTH_SPEED-1:0] LIMIT     = WIDTH_SPEED'(SPEED_LIMIT);
   localparam logic [1:0]             FULL      = 2'(MAX_VEH);

   // Sensor vector bit positions
   localparam int unsigned S1  = 0;
   localparam int unsigned S2  = 1;
   localparam int unsigned SEX = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      INIT     = 3'd1,
      COUNT    = 3'd2,
      CALC     = 3'd3,
      WAIT_DIV = 3'd4,
      DECIDE   = 3'd5,
      OPEN     = 3'd6,
      ABORT    = 3'd7
   } state_e;

   state_e state_q, state_d;

   logic [2:0]       meta_q, sync_q, prev_q;
   logic [2:0]       rise;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [OPN_W-1:0] open_q, open_d;

   logic init_q,  init_d;
   logic count_q, count_d;
   logic cal_q,   cal_d;
   logic up_q,    up_d;
   logic down_q,  down_d;
   logic en_q,    en_d;
   logic dis_q,   dis_d;
   logic ovs_q,   ovs_d;
   logic busy_q,  busy_d;

   // Two-flop synchronizer plus a third flop for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 3'b000;
         sync_q <= 3'b000;
         prev_q <= 3'b000;
      end else begin
         meta_q <= {exit_sen, sen2, sen1};
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise = sync_q & ~prev_q;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         open_q  <= '0;
         init_q  <= 1'b0;
         count_q <= 1'b0;
         cal_q   <= 1'b0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         en_q    <= 1'b0;
         dis_q   <= 1'b0;
         ovs_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         open_q  <= open_d;
         init_q  <= init_d;
         count_q <= count_d;
         cal_q   <= cal_d;
         up_q    <= up_d;
         down_q  <= down_d;
         en_q    <= en_d;
         dis_q   <= dis_d;
         ovs_q   <= ovs_d;
         busy_q  <= busy_d;
      end
   end

   // Next state and next outputs. Strobes are decoded from the transition
   // being taken so the registered pulse lines up with the state it names.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      open_d  = open_q;
      init_d  = 1'b0;
      count_d = 1'b0;
      cal_d   = 1'b0;
      up_d    = 1'b0;
      en_d    = 1'b0;
      dis_d   = 1'b0;
      ovs_d   = ovs_q;
      busy_d  = (state_q != IDLE);

      // Exit path is independent of the FSM; an empty lot drops the edge
      down_d  = rise[SEX] && (num_veh != 2'd0);

      unique case (state_q)
         IDLE: begin
            if (rise[S1]) begin
               state_d = INIT;
               init_d  = 1'b1;
               // Cleared on entry so the flag already reads 0 during INIT
               ovs_d   = 1'b0;
            end
         end

         INIT: begin
            tmo_d   = '0;
            state_d = COUNT;
            count_d = 1'b1;
         end

         COUNT: begin
            // A sen2 edge wins over a timeout landing in the same cycle
            if (rise[S2]) begin
               state_d = CALC;
               cal_d   = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ABORT;
               dis_d   = 1'b1;
            end else begin
               count_d = 1'b1;
               tmo_d   = tmo_q + TMO_W'(1);
            end
         end

         CALC: begin
            tmo_d   = '0;
            state_d = WAIT_DIV;
         end

         WAIT_DIV: begin
            if (done) begin
               state_d = DECIDE;
               ovs_d   = (speed > LIMIT);
            end else if (tmo_q == TMO_LAST) begin
               state_d = ABORT;
               dis_d   = 1'b1;
            end else begin
               tmo_d   = tmo_q + TMO_W'(1);
            end
         end

         DECIDE: begin
            // Overspeed never blocks admission, only a full lot does
            if (num_veh == FULL) begin
               state_d = IDLE;
               dis_d   = 1'b1;
            end else begin
               state_d = OPEN;
               up_d    = 1'b1;
               en_d    = 1'b1;
               open_d  = '0;
            end
         end

         OPEN: begin
            // open_q counts en cycles already shown; the last one ends here
            if (open_q == OPEN_LAST) begin
               state_d = IDLE;
               dis_d   = 1'b1;
            end else begin
               en_d    = 1'b1;
               open_d  = open_q + OPN_W'(1);
            end
         end

         ABORT: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign init      = init_q;
   assign count     = count_q;
   assign cal       = cal_q;
   assign up        = up_q;
   assign down      = down_q;
   assign en        = en_q;
   assign dis       = dis_q;
   assign overspeed = ovs_q;
   assign busy      = busy_q;

endmodule
